// File: rtl/mnacidpro_seq.sv
// Protocol sequencer for the nucleic-acid purification chip: steps the valve map and
// peristaltic pump through load, lyse, mix, bind, wash and elute for programmable stroke counts.
module mnacidpro_seq #(
    parameter int PUMP_DIV = 4,
    parameter int STROKE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [STROKE_W-1:0] load_n,
    input  logic [STROKE_W-1:0] lyse_n,
    input  logic [STROKE_W-1:0] mix_n,
    input  logic [STROKE_W-1:0] bind_n,
    input  logic [STROKE_W-1:0] wash_n,
    input  logic [STROKE_W-1:0] elute_n,
    output logic                lysis_ctrl,
    output logic                wash_ctrl,
    output logic                elute_ctrl,
    output logic                dead_end_ctrl,
    output logic                vertical_ctrl,
    output logic                horiz_ctrl,
    output logic                waste_ctrl,
    output logic                bead_ctrl,
    output logic                loop_exit_ctrl,
    output logic                bead_trap_ctrl,
    output logic                collect_ctrl,
    output logic [2:0]          pump,
    output logic [2:0]          state_o,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_LYSE  = 3'd2;
    localparam logic [2:0] S_MIX   = 3'd3;
    localparam logic [2:0] S_BIND  = 3'd4;
    localparam logic [2:0] S_WASH  = 3'd5;
    localparam logic [2:0] S_ELUTE = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int              DIV_W      = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PUMP_DIV - 1);
    localparam logic [2:0]      PHASE_LAST = 3'd5;

    // Bit positions in the internal valve vector.
    localparam int V_LYSIS     = 10;
    localparam int V_WASH      = 9;
    localparam int V_ELUTE     = 8;
    localparam int V_DEAD_END  = 7;
    localparam int V_VERTICAL  = 6;
    localparam int V_HORIZ     = 5;
    localparam int V_WASTE     = 4;
    localparam int V_BEAD      = 3;
    localparam int V_LOOP_EXIT = 2;
    localparam int V_BEAD_TRAP = 1;
    localparam int V_COLLECT   = 0;

    logic [2:0]          state, state_nxt;
    logic [DIV_W-1:0]    div, div_nxt;
    logic [2:0]          phase, phase_nxt;
    logic [STROKE_W-1:0] stroke, stroke_nxt;
    logic                aborted_nxt;
    logic [STROKE_W-1:0] step_n;
    logic                step_last;
    logic [10:0]         valves;

    always_comb begin
        step_n = '0;
        case (state)
            S_LOAD:  step_n = load_n;
            S_LYSE:  step_n = lyse_n;
            S_MIX:   step_n = mix_n;
            S_BIND:  step_n = bind_n;
            S_WASH:  step_n = wash_n;
            S_ELUTE: step_n = elute_n;
            default: step_n = '0;
        endcase
    end

    // A zero-stroke step still occupies one cycle; otherwise leave on the last phase of stroke N-1.
    assign step_last = (step_n == '0) ||
                       ((div == DIV_LAST) && (phase == PHASE_LAST) &&
                        (stroke == step_n - STROKE_W'(1)));

    // NOTE: every variable gets a default at the top of the block, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div;
        phase_nxt   = phase;
        stroke_nxt  = stroke;
        aborted_nxt = 1'b0;
        if (abort && (state != S_IDLE)) begin
            state_nxt   = S_IDLE;
            div_nxt     = '0;
            phase_nxt   = '0;
            stroke_nxt  = '0;
            aborted_nxt = 1'b1;
        end else if ((state == S_IDLE) || (state == S_DONE)) begin
            if (start) begin
                state_nxt  = S_LOAD;
                div_nxt    = '0;
                phase_nxt  = '0;
                stroke_nxt = '0;
            end
        end else if (step_last) begin
            state_nxt  = state + 3'd1;
            div_nxt    = '0;
            phase_nxt  = '0;
            stroke_nxt = '0;
        end else if (div == DIV_LAST) begin
            div_nxt = '0;
            if (phase == PHASE_LAST) begin
                phase_nxt  = '0;
                stroke_nxt = stroke + STROKE_W'(1);
            end else begin
                phase_nxt = phase + 3'd1;
            end
        end else begin
            div_nxt = div + DIV_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            div     <= '0;
            phase   <= '0;
            stroke  <= '0;
            aborted <= 1'b0;
        end else begin
            state   <= state_nxt;
            div     <= div_nxt;
            phase   <= phase_nxt;
            stroke  <= stroke_nxt;
            aborted <= aborted_nxt;
        end
    end

    always_comb begin
        valves = '1;
        case (state)
            S_LOAD: begin
                valves[V_BEAD]      = 1'b0;
                valves[V_BEAD_TRAP] = 1'b0;
                valves[V_WASTE]     = 1'b0;
            end
            S_LYSE: begin
                valves[V_LYSIS]    = 1'b0;
                valves[V_DEAD_END] = 1'b0;
            end
            S_MIX: begin
                valves[V_VERTICAL] = 1'b0;
                valves[V_HORIZ]    = 1'b0;
            end
            S_BIND: begin
                valves[V_LOOP_EXIT] = 1'b0;
                valves[V_BEAD_TRAP] = 1'b0;
                valves[V_WASTE]     = 1'b0;
            end
            S_WASH: begin
                valves[V_WASH]      = 1'b0;
                valves[V_BEAD_TRAP] = 1'b0;
                valves[V_WASTE]     = 1'b0;
            end
            S_ELUTE: begin
                valves[V_ELUTE]     = 1'b0;
                valves[V_BEAD_TRAP] = 1'b0;
                valves[V_COLLECT]   = 1'b0;
            end
            default: valves = '1;
        endcase
    end

    always_comb begin
        pump = 3'b111;
        if (busy) begin
            case (phase)
                3'd0:    pump = 3'b110;
                3'd1:    pump = 3'b100;
                3'd2:    pump = 3'b101;
                3'd3:    pump = 3'b001;
                3'd4:    pump = 3'b011;
                3'd5:    pump = 3'b010;
                default: pump = 3'b111;
            endcase
        end
    end

    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign state_o = state;

    assign lysis_ctrl     = valves[V_LYSIS];
    assign wash_ctrl      = valves[V_WASH];
    assign elute_ctrl     = valves[V_ELUTE];
    assign dead_end_ctrl  = valves[V_DEAD_END];
    assign vertical_ctrl  = valves[V_VERTICAL];
    assign horiz_ctrl     = valves[V_HORIZ];
    assign waste_ctrl     = valves[V_WASTE];
    assign bead_ctrl      = valves[V_BEAD];
    assign loop_exit_ctrl = valves[V_LOOP_EXIT];
    assign bead_trap_ctrl = valves[V_BEAD_TRAP];
    assign collect_ctrl   = valves[V_COLLECT];

endmodule

// File: tb/tb_mnacidpro_seq.sv
// Bench for mnacidpro_seq: two instances (PUMP_DIV=2 and 1) share stimulus; each scenario is
// compared cycle by cycle against a trace computed from step durations and phase arithmetic.
module tb_mnacidpro_seq;

    localparam int SW = 16;

    localparam int LYSIS = 10, WASH = 9, ELUTE = 8, DEAD_END = 7, VERTICAL = 6, HORIZ = 5;
    localparam int WASTE = 4, BEAD = 3, LOOP_EXIT = 2, BEAD_TRAP = 1, COLLECT = 0;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic [SW-1:0] load_n, lyse_n, mix_n, bind_n, wash_n, elute_n;

    wire [10:0] v0, v1;
    wire [2:0]  p0, p1, st0, st1;
    wire        b0, b1, d0, d1, a0, a1;

    int n_vec = 0;
    int n_err = 0;
    int nsteps[6];
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    mnacidpro_seq #(.PUMP_DIV(2), .STROKE_W(SW)) dut_div2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .load_n(load_n), .lyse_n(lyse_n), .mix_n(mix_n), .bind_n(bind_n),
        .wash_n(wash_n), .elute_n(elute_n),
        .lysis_ctrl(v0[LYSIS]), .wash_ctrl(v0[WASH]), .elute_ctrl(v0[ELUTE]),
        .dead_end_ctrl(v0[DEAD_END]), .vertical_ctrl(v0[VERTICAL]), .horiz_ctrl(v0[HORIZ]),
        .waste_ctrl(v0[WASTE]), .bead_ctrl(v0[BEAD]), .loop_exit_ctrl(v0[LOOP_EXIT]),
        .bead_trap_ctrl(v0[BEAD_TRAP]), .collect_ctrl(v0[COLLECT]),
        .pump(p0), .state_o(st0), .busy(b0), .done(d0), .aborted(a0)
    );

    mnacidpro_seq #(.PUMP_DIV(1), .STROKE_W(SW)) dut_div1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .load_n(load_n), .lyse_n(lyse_n), .mix_n(mix_n), .bind_n(bind_n),
        .wash_n(wash_n), .elute_n(elute_n),
        .lysis_ctrl(v1[LYSIS]), .wash_ctrl(v1[WASH]), .elute_ctrl(v1[ELUTE]),
        .dead_end_ctrl(v1[DEAD_END]), .vertical_ctrl(v1[VERTICAL]), .horiz_ctrl(v1[HORIZ]),
        .waste_ctrl(v1[WASTE]), .bead_ctrl(v1[BEAD]), .loop_exit_ctrl(v1[LOOP_EXIT]),
        .bead_trap_ctrl(v1[BEAD_TRAP]), .collect_ctrl(v1[COLLECT]),
        .pump(p1), .state_o(st1), .busy(b1), .done(d1), .aborted(a1)
    );

    // Observed outputs packed as {state[19:17], valves[16:6], pump[5:3], busy, done, aborted}.
    function automatic logic [19:0] obs(input int sel);
        if (sel == 1) return {st1, v1, p1, b1, d1, a1};
        return {st0, v0, p0, b0, d0, a0};
    endfunction

    // Expected outputs for a step code, pump phase and abort flag, straight from the valve table.
    function automatic logic [19:0] exp_vec(input int st, input int ph, input bit ab);
        logic [10:0] v;
        logic [2:0]  p;
        logic [2:0]  pump_tab[6];
        pump_tab = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
        v = '1;
        case (st)
            1: begin v[BEAD] = 0; v[BEAD_TRAP] = 0; v[WASTE] = 0; end
            2: begin v[LYSIS] = 0; v[DEAD_END] = 0; end
            3: begin v[VERTICAL] = 0; v[HORIZ] = 0; end
            4: begin v[LOOP_EXIT] = 0; v[BEAD_TRAP] = 0; v[WASTE] = 0; end
            5: begin v[WASH] = 0; v[BEAD_TRAP] = 0; v[WASTE] = 0; end
            6: begin v[ELUTE] = 0; v[BEAD_TRAP] = 0; v[COLLECT] = 0; end
            default: v = '1;
        endcase
        p = (st >= 1 && st <= 6) ? pump_tab[ph] : 3'b111;
        return {3'(st), v, p, 1'(st >= 1 && st <= 6), 1'(st == 7), ab};
    endfunction

    // Whole-program trace: step s lasts N*6*pd cycles (phase = (i/pd)%6) or one cycle when N=0.
    task automatic build_trace(input int pd);
        exp_q.delete();
        for (int s = 0; s < 6; s++) begin
            if (nsteps[s] == 0) exp_q.push_back(exp_vec(s + 1, 0, 1'b0));
            else for (int i = 0; i < nsteps[s] * 6 * pd; i++)
                exp_q.push_back(exp_vec(s + 1, (i / pd) % 6, 1'b0));
        end
        exp_q.push_back(exp_vec(7, 0, 1'b0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_n();
        load_n = SW'(nsteps[0]); lyse_n = SW'(nsteps[1]); mix_n  = SW'(nsteps[2]);
        bind_n = SW'(nsteps[3]); wash_n = SW'(nsteps[4]); elute_n = SW'(nsteps[5]);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        start = 0; abort = 0;
        #2 rst_n = 0;
        #2 rst_n = 1;
    endtask

    // Runs one program on instance sel; start_mode 0: quiet, 1: random start while busy, 2: start held while busy.
    task automatic run_program(input int sel, input string tag, input int start_mode);
        logic [19:0] got;
        drive_n();
        build_trace(sel == 1 ? 1 : 2);
        start = 1; step(); start = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = obs(sel);
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, i + 1, got, exp_q[i]);
            end
            if (exp_q[i][19:17] inside {[3'd1:3'd6]})
                start = (start_mode == 2) ? 1'b1 : (start_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            else
                start = 0;
            step();
        end
        start = 0;
    endtask

    task automatic test_reset();
        logic [19:0] idle;
        idle = exp_vec(0, 0, 1'b0);
        for (int s = 0; s < 2; s++) begin
            n_vec++;
            if (obs(s) !== idle) begin
                n_err++;
                $display("FAIL reset_state inst%0d: got %h expected %h", s, obs(s), idle);
            end
        end
        @(negedge clk) rst_n = 1;
        nsteps = '{1, 1, 1, 1, 1, 1};
        drive_n();
        step();
        start = 1; step(); start = 0;
        repeat (49) step();
        n_vec++;
        if (st0 !== 3'd5) begin
            n_err++;
            $display("FAIL reset_reach_wash: got state %0d expected 5", st0);
        end
        #2 rst_n = 0;
        #1;
        for (int s = 0; s < 2; s++) begin
            n_vec++;
            if (obs(s) !== idle) begin
                n_err++;
                $display("FAIL reset_mid_wash inst%0d: got %h expected %h", s, obs(s), idle);
            end
        end
        #2 rst_n = 1;
    endtask

    task automatic test_full_run();
        reset_dut();
        nsteps = '{1, 1, 1, 1, 1, 1};
        run_program(0, "full_run_div2", 0);
    endtask

    task automatic test_stroke_count();
        reset_dut();
        for (int s = 0; s < 6; s++) nsteps[s] = $urandom_range(0, 2);
        nsteps[4] = 3;
        run_program(1, "stroke_count_div1", 0);
    endtask

    task automatic test_n_zero();
        reset_dut();
        for (int s = 0; s < 6; s++) nsteps[s] = $urandom_range(1, 2);
        nsteps[2] = 0;
        run_program(0, "n_zero_mix", 0);
    endtask

    task automatic test_random();
        int sel;
        for (int it = 0; it < 6; it++) begin
            reset_dut();
            sel = $urandom_range(0, 1);
            for (int s = 0; s < 6; s++) nsteps[s] = $urandom_range(0, 3);
            run_program(sel, $sformatf("random_run%0d_inst%0d", it, sel), 1);
        end
    endtask

    task automatic test_abort();
        logic [19:0] got, want;
        int j;
        reset_dut();
        for (int s = 0; s < 6; s++) nsteps[s] = $urandom_range(1, 2);
        drive_n();
        build_trace(2);
        j = 0;
        while (!(exp_q[j][19:17] == 3'd3 && exp_q[j + 1][19:17] == 3'd4)) j++;
        start = 1; step(); start = 0;
        for (int i = 0; i < j; i++) step();
        n_vec++;
        if (obs(0) !== exp_q[j]) begin
            n_err++;
            $display("FAIL abort_reach_mix_end: got %h expected %h", obs(0), exp_q[j]);
        end
        abort = 1; start = 1; step(); abort = 0; start = 0;
        want = exp_vec(0, 0, 1'b1);
        n_vec++;
        if (obs(0) !== want) begin
            n_err++;
            $display("FAIL abort_pulse: got %h expected %h", obs(0), want);
        end
        step();
        want = exp_vec(0, 0, 1'b0);
        n_vec++;
        if (obs(0) !== want) begin
            n_err++;
            $display("FAIL abort_pulse_end: got %h expected %h", obs(0), want);
        end
        abort = 1; step(); abort = 0;
        n_vec++;
        if (obs(0) !== want) begin
            n_err++;
            $display("FAIL abort_in_idle: got %h expected %h", obs(0), want);
        end
        start = 1; step(); start = 0;
        for (int i = 0; i < 14; i++) begin
            got = obs(0);
            n_vec++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL abort_restart cycle %0d: got %h expected %h", i + 1, got, exp_q[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] want;
        reset_dut();
        nsteps = '{1, 1, 1, 1, 1, 1};
        run_program(0, "start_while_busy", 2);
        start = 1; step(); start = 0;
        want = exp_vec(1, 0, 1'b0);
        n_vec++;
        if (obs(0) !== want) begin
            n_err++;
            $display("FAIL start_in_done: got %h expected %h", obs(0), want);
        end
        step();
        n_vec++;
        if (obs(0) !== want) begin
            n_err++;
            $display("FAIL start_in_done_hold: got %h expected %h", obs(0), want);
        end
        abort = 1; step(); abort = 0;
        want = exp_vec(0, 0, 1'b1);
        n_vec++;
        if (obs(0) !== want) begin
            n_err++;
            $display("FAIL abort_from_load: got %h expected %h", obs(0), want);
        end
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0;
        nsteps = '{1, 1, 1, 1, 1, 1};
        drive_n();
        #1;
        test_reset();
        test_full_run();
        test_stroke_count();
        test_n_zero();
        test_random();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mnacidpro_seq.md
# mnacidpro_seq

Protocol sequencer for the nucleic-acid purification chip. It drives the 11 named valve control lines and the 3-valve peristaltic pump of the chip through a fixed load, lyse, mix, bind, wash, elute program. Each step runs for a programmable number of pump strokes. It sits between the host/test controller and the chip's `ctrl` inputs; flush lines are handled elsewhere.

## Interface
- `PUMP_DIV`, default 4: clock cycles per pump phase, must be ≥1.
- `STROKE_W`, default 16: width of the stroke counter and stroke-count inputs.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin program; sampled in IDLE or DONE only.
- `abort`  in  1  cancel program; highest priority.
- `load_n, lyse_n, mix_n, bind_n, wash_n, elute_n`  in  STROKE_W each  stroke counts per step. Must be held stable while `busy`.
- `lysis_ctrl, wash_ctrl, elute_ctrl, dead_end_ctrl, vertical_ctrl, horiz_ctrl, waste_ctrl, bead_ctrl, loop_exit_ctrl, bead_trap_ctrl, collect_ctrl`  out  1 each  valve control; 1 = closed/pressurised, 0 = open.
- `pump`  out  3  peristaltic pump valves, same polarity.
- `state_o`  out  3  current step code.
- `busy`  out  1  high in steps LOAD..ELUTE.
- `done`  out  1  high in DONE.
- `aborted`  out  1  one-cycle pulse after an abort takes effect.

## Operation
- States and `state_o` codes: IDLE=0, LOAD=1, LYSE=2, MIX=3, BIND=4, WASH=5, ELUTE=6, DONE=7.
- Step order: LOAD→LYSE→MIX→BIND→WASH→ELUTE→DONE.
- Valves open per step; every valve not listed is 1:
  - IDLE/DONE: all valves closed, `pump`=3'b111.
  - LOAD: bead, bead_trap, waste.
  - LYSE: lysis, dead_end.
  - MIX: vertical, horiz (closed ring; loop_exit stays closed).
  - BIND: loop_exit, bead_trap, waste.
  - WASH: wash, bead_trap, waste.
  - ELUTE: elute, bead_trap, collect.
- Pump pattern in stepping states, by phase 0..5: 3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010. One stroke = 6 phases = 6·PUMP_DIV cycles.
- Counters:
  - Divider counts 0..PUMP_DIV-1. At terminal count the phase advances, wrapping 5→0.
  - When the phase wraps 5→0, the stroke counter increments.
  - When the stroke counter reaches the step's N-1 at the phase-5 terminal cycle, the FSM moves to the next step. Divider, phase and stroke all clear to 0.
- N=0: the step lasts exactly one cycle, outputting its valve map with phase 0, then advances.
- Stroke counter is STROKE_W bits and never wraps; N up to 2^STROKE_W−1 is legal.
- `start` in IDLE or DONE → LOAD. `start` while `busy` is ignored.
- `abort` in any busy step or DONE → IDLE, counters cleared, `aborted` pulses. Abort in IDLE has no effect and no pulse. Abort beats start and beats a step advance in the same cycle.
- DONE holds until `start` (→LOAD) or `abort` (→IDLE).

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, all counters 0, all valve outputs 1, `pump`=3'b111, `busy`=0, `done`=0, `aborted`=0, `state_o`=0.
- All outputs decode only registered state/phase. There is no combinational input→output path.
- `start` sampled at edge k: state LOAD, phase 0, pump 3'b110 visible after edge k.
- Step duration = N·6·PUMP_DIV cycles for N≥1, or 1 cycle for N=0.
- Abort sampled at edge k: IDLE outputs and `aborted`=1 after edge k; `aborted`=0 after edge k+1.
- Reset asserted mid-step: outputs return to reset values immediately (asynchronously). Deassertion restarts in IDLE.

## Test plan
- Reset: assert `rst_n`=0 mid-WASH → same-cycle all valves 1, `pump`=3'b111, `state_o`=0, `busy`=0.
- Full run, PUMP_DIV=2, all N=1, `start` at edge 0:
  - `state_o`=1 for cycles 1–12, then 2…6 in 12-cycle blocks.
  - `done`=1 and `state_o`=7 from cycle 73.
  - LOAD pump sequence 110,110,100,100,101,101,001,001,011,011,010,010.
- Stroke count, PUMP_DIV=1, wash_n=3: WASH lasts exactly 18 cycles. wash/bead_trap/waste =0, all others 1 throughout.
- N=0 skip, mix_n=0: `state_o`=3 for exactly one cycle, valves vertical/horiz=0, pump 3'b110, then BIND.
- Abort in MIX coincident with `start` and a step-advance cycle: next cycle IDLE, `aborted`=1 for one cycle, counters 0. A later `start` re-enters LOAD at phase 0.
- `start` while busy (ELUTE) → no effect on state or counters. `start` in DONE → LOAD next cycle, `done`=0.
